// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the dual-equation pipeline.
//   EQ_ALT / EQ_BAT : equation tags carried with every transaction
//   SR_MAXW         : working width of the reduction helper
//   sat_reduce()    : reduces an exact signed sum to an ow-bit result,
//                     either clamping or wrapping, and returns {flag, value}
// ---------------------------------------------------------------------------
package eq_pkg;

    localparam logic EQ_ALT = 1'b0;
    localparam logic EQ_BAT = 1'b1;

    // The helper works on one wide signed width so that it can serve any
    // result width up to SR_MAXW-1 bits; callers sign-extend into it.
    localparam int SR_MAXW = 64;

    // Reduce an exact sum to ow bits.
    //   sat_en=1: clamp to [-2^(ow-1), 2^(ow-1)-1], flag = value was clamped
    //   sat_en=0: keep the low ow bits, flag = dropped bits were not a pure
    //             sign extension (i.e. the wrapped value differs from the sum)
    // The returned value is sign-extended back to SR_MAXW bits.
    function automatic logic [SR_MAXW:0] sat_reduce(
        input logic signed [SR_MAXW-1:0] sum,
        input logic                      sat_en,
        input int                        ow
    );
        logic signed [SR_MAXW-1:0] hi_s;
        logic signed [SR_MAXW-1:0] lo_s;
        logic signed [SR_MAXW-1:0] wrap_s;
        logic signed [SR_MAXW-1:0] val_s;
        logic                      flag_s;
        hi_s   = (64'sd1 <<< (ow - 32'sd1)) - 64'sd1;
        lo_s   = -hi_s - 64'sd1;
        // Shift the low ow bits to the top, then arithmetic-shift back down.
        wrap_s = (sum <<< (SR_MAXW - ow)) >>> (SR_MAXW - ow);
        if (sat_en) begin
            if (sum > hi_s) begin
                val_s  = hi_s;
                flag_s = 1'b1;
            end else if (sum < lo_s) begin
                val_s  = lo_s;
                flag_s = 1'b1;
            end else begin
                val_s  = sum;
                flag_s = 1'b0;
            end
        end else begin
            val_s  = wrap_s;
            flag_s = (wrap_s != sum);
        end
        return {flag_s, val_s};
    endfunction

endpackage

// File: rtl/dual_eq_pipe_if.sv
// ---------------------------------------------------------------------------
// dual_eq_pipe_if
// Bundles the upstream (operand) and downstream (result) handshakes of
// dual_eq_pipe plus its result counters.
//   master : the side that drives operands and out_ready (source/sink)
//   slave  : the pipeline itself
// Signals
//   in_valid, in_ready, sel_eq, x1, x2, v, t, c   upstream transaction
//   out_valid, out_ready, out_eq, out_result,
//   out_sat                                       downstream result
//   alt_cnt, bat_cnt                              handed-off result counts
// ---------------------------------------------------------------------------
interface dual_eq_pipe_if #(
    parameter int DW = 8,
    parameter int OW = 16,
    parameter int CW = 16
);
    import eq_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 sel_eq;
    logic signed [DW-1:0] x1;
    logic signed [DW-1:0] x2;
    logic signed [DW-1:0] v;
    logic signed [DW-1:0] t;
    logic signed [DW-1:0] c;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_eq;
    logic signed [OW-1:0] out_result;
    logic                 out_sat;
    logic [CW-1:0]        alt_cnt;
    logic [CW-1:0]        bat_cnt;

    modport master (
        output in_valid, sel_eq, x1, x2, v, t, c, out_ready,
        input  in_ready, out_valid, out_eq, out_result, out_sat, alt_cnt, bat_cnt
    );

    modport slave (
        input  in_valid, sel_eq, x1, x2, v, t, c, out_ready,
        output in_ready, out_valid, out_eq, out_result, out_sat, alt_cnt, bat_cnt
    );

endinterface

// File: rtl/eq_sat_reduce.sv
// ---------------------------------------------------------------------------
// eq_sat_reduce
// Combinational final stage: reduces an exact IW-bit signed sum to an OW-bit
// signed result, clamping (SAT=1) or wrapping (SAT=0), and raises flag when
// the result does not equal the exact sum.
// Ports
//   sum     in   IW  exact signed sum
//   result  out  OW  reduced signed result
//   flag    out  1   clamped (SAT=1) / overflowed (SAT=0)
// ---------------------------------------------------------------------------
module eq_sat_reduce
    import eq_pkg::*;
#(
    parameter int IW  = 18,
    parameter int OW  = 16,
    parameter int SAT = 1
) (
    input  logic signed [IW-1:0] sum,
    output logic signed [OW-1:0] result,
    output logic                 flag
);

    logic signed [SR_MAXW-1:0] wide_s;
    logic [SR_MAXW:0]          red_s;
    logic [SR_MAXW-OW-1:0]     unused_hi_s;

    // Widen the sum, reduce it and split the packed {flag, value} answer.
    always_comb begin
        wide_s = {{(SR_MAXW-IW){sum[IW-1]}}, sum};
        red_s  = sat_reduce(wide_s, (SAT != 32'sd0), OW);
        result = red_s[OW-1:0];
        flag   = red_s[SR_MAXW];
    end

    // Upper value bits are only a sign extension of result.
    assign unused_hi_s = red_s[SR_MAXW-1:OW];

endmodule

// File: rtl/dual_eq_pipe.sv
// ---------------------------------------------------------------------------
// dual_eq_pipe
// Three-stage signed datapath computing, per accepted transaction, either
//   ALT = CA*x1 + CB*x2     (sel_eq = 0)
//   BAT = v*t + c           (sel_eq = 1)
// with optional saturation to OW bits and per-equation hand-off counters.
// The whole pipe advances together whenever the output register is empty or
// being drained (en = !out_valid | out_ready); otherwise every stage holds.
// Ports
//   clk   in  1   rising-edge clock
//   rst   in  1   synchronous active-low reset
//   bus   slave modport of dual_eq_pipe_if (operands, results, counters)
// ---------------------------------------------------------------------------
module dual_eq_pipe
    import eq_pkg::*;
#(
    parameter int DW  = 8,
    parameter int OW  = 2*DW,
    parameter int CA  = 3,
    parameter int CB  = 5,
    parameter int SAT = 1,
    parameter int CW  = 16
) (
    input logic           clk,
    input logic           rst,
    dual_eq_pipe_if.slave bus
);

    // Internal width: two guard bits above the larger of OW and a full DW*DW
    // product, so products and their sum stay exact even when OW is narrowed
    // below 2*DW and the reducer has to see the true value to clamp it.
    localparam int PW = ((OW > 2*DW) ? OW : 2*DW) + 2;

    localparam logic signed [PW-1:0] CA_W = PW'(CA);
    localparam logic signed [PW-1:0] CB_W = PW'(CB);

    logic                 en_s;

    logic                 s1_valid_r;
    logic                 s1_sel_r;
    logic signed [DW-1:0] s1_x1_r;
    logic signed [DW-1:0] s1_x2_r;
    logic signed [DW-1:0] s1_v_r;
    logic signed [DW-1:0] s1_t_r;
    logic signed [DW-1:0] s1_c_r;

    logic signed [PW-1:0] p0_s;
    logic signed [PW-1:0] p1_s;

    logic                 s2_valid_r;
    logic                 s2_sel_r;
    logic signed [PW-1:0] s2_p0_r;
    logic signed [PW-1:0] s2_p1_r;

    logic signed [PW-1:0] sum_s;
    logic signed [OW-1:0] red_result_s;
    logic                 red_flag_s;

    logic                 out_valid_r;
    logic                 out_eq_r;
    logic signed [OW-1:0] out_result_r;
    logic                 out_sat_r;

    logic [CW-1:0]        alt_cnt_r;
    logic [CW-1:0]        bat_cnt_r;

    // Sign-extend an operand to the internal width.
    function automatic logic signed [PW-1:0] sext(input logic signed [DW-1:0] a);
        return {{(PW-DW){a[DW-1]}}, a};
    endfunction

    // Global advance: free when the result register is empty or being taken.
    always_comb begin
        en_s = ~out_valid_r | bus.out_ready;
    end

    // Stage 1: capture operands, tag and valid (bubbles enter as valid=0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_sel_r   <= EQ_ALT;
            s1_x1_r    <= '0;
            s1_x2_r    <= '0;
            s1_v_r     <= '0;
            s1_t_r     <= '0;
            s1_c_r     <= '0;
        end else if (en_s) begin
            s1_valid_r <= bus.in_valid;
            s1_sel_r   <= bus.sel_eq;
            s1_x1_r    <= bus.x1;
            s1_x2_r    <= bus.x2;
            s1_v_r     <= bus.v;
            s1_t_r     <= bus.t;
            s1_c_r     <= bus.c;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 operands: pick the two addends for the selected equation.
    always_comb begin
        p0_s = '0;
        p1_s = '0;
        if (s1_sel_r == EQ_BAT) begin
            p0_s = sext(s1_v_r) * sext(s1_t_r);
            p1_s = sext(s1_c_r);
        end else begin
            p0_s = CA_W * sext(s1_x1_r);
            p1_s = CB_W * sext(s1_x2_r);
        end
    end

    // Stage 2 register: addends plus tag and valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_sel_r   <= EQ_ALT;
            s2_p0_r    <= '0;
            s2_p1_r    <= '0;
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sel_r   <= s1_sel_r;
            s2_p0_r    <= p0_s;
            s2_p1_r    <= p1_s;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Stage 3 sum: exact at PW bits by construction.
    always_comb begin
        sum_s = s2_p0_r + s2_p1_r;
    end

    eq_sat_reduce #(
        .IW  (PW),
        .OW  (OW),
        .SAT (SAT)
    ) u_sat_reduce (
        .sum    (sum_s),
        .result (red_result_s),
        .flag   (red_flag_s)
    );

    // Stage 3 register: the presented result, frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_r  <= 1'b0;
            out_eq_r     <= EQ_ALT;
            out_result_r <= '0;
            out_sat_r    <= 1'b0;
        end else if (en_s) begin
            out_valid_r  <= s2_valid_r;
            out_eq_r     <= s2_sel_r;
            out_result_r <= red_result_s;
            out_sat_r    <= red_flag_s;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    // Hand-off counters, one per equation, free-running wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alt_cnt_r <= '0;
            bat_cnt_r <= '0;
        end else if (out_valid_r && bus.out_ready) begin
            if (out_eq_r == EQ_ALT) begin
                alt_cnt_r <= alt_cnt_r + CW'(1'b1);
            end else begin
                bat_cnt_r <= bat_cnt_r + CW'(1'b1);
            end
        end else begin
            alt_cnt_r <= alt_cnt_r;
        end
    end

    assign bus.in_ready   = en_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_eq     = out_eq_r;
    assign bus.out_result = out_result_r;
    assign bus.out_sat    = out_sat_r;
    assign bus.alt_cnt    = alt_cnt_r;
    assign bus.bat_cnt    = bat_cnt_r;

endmodule

// File: tb/tb_dual_eq_pipe.sv
// ---------------------------------------------------------------------------
// tb_dual_eq_pipe
// Three pipes share one stimulus stream: default (OW=16, SAT=1), narrow
// saturating (OW=10, SAT=1) and narrow wrapping with 2-bit counters
// (OW=10, SAT=0, CW=2). A queue of accepted transactions is the reference;
// every result is recomputed from the equations with plain integer maths.
// ---------------------------------------------------------------------------
module tb_dual_eq_pipe;
    import eq_pkg::*;

    localparam int CA = 3;
    localparam int CB = 5;

    typedef struct {
        bit sel;
        int x1, x2, v, t, c;
    } txn_t;

    logic clk, rst;
    logic in_valid_d, sel_eq_d, out_ready_d;
    logic signed [7:0] x1_d, x2_d, v_d, t_d, c_d;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    txn_t q[$];
    int   m_alt = 0, m_bat = 0, m_acc = 0;

    dual_eq_pipe_if #(.DW(8), .OW(16), .CW(16)) bus_a ();
    dual_eq_pipe_if #(.DW(8), .OW(10), .CW(16)) bus_s ();
    dual_eq_pipe_if #(.DW(8), .OW(10), .CW(2))  bus_w ();

    dual_eq_pipe #(.DW(8), .OW(16), .CA(CA), .CB(CB), .SAT(1), .CW(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    dual_eq_pipe #(.DW(8), .OW(10), .CA(CA), .CB(CB), .SAT(1), .CW(16))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    dual_eq_pipe #(.DW(8), .OW(10), .CA(CA), .CB(CB), .SAT(0), .CW(2))
        dut_w (.clk(clk), .rst(rst), .bus(bus_w));

    assign bus_a.in_valid = in_valid_d;  assign bus_s.in_valid = in_valid_d;  assign bus_w.in_valid = in_valid_d;
    assign bus_a.sel_eq = sel_eq_d;      assign bus_s.sel_eq = sel_eq_d;      assign bus_w.sel_eq = sel_eq_d;
    assign bus_a.x1 = x1_d;              assign bus_s.x1 = x1_d;              assign bus_w.x1 = x1_d;
    assign bus_a.x2 = x2_d;              assign bus_s.x2 = x2_d;              assign bus_w.x2 = x2_d;
    assign bus_a.v = v_d;                assign bus_s.v = v_d;                assign bus_w.v = v_d;
    assign bus_a.t = t_d;                assign bus_s.t = t_d;                assign bus_w.t = t_d;
    assign bus_a.c = c_d;                assign bus_s.c = c_d;                assign bus_w.c = c_d;
    assign bus_a.out_ready = out_ready_d; assign bus_s.out_ready = out_ready_d; assign bus_w.out_ready = out_ready_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Exact value of the selected equation.
    function automatic longint exact(input txn_t tr);
        if (tr.sel) return longint'(tr.v) * longint'(tr.t) + longint'(tr.c);
        else        return longint'(CA) * longint'(tr.x1) + longint'(CB) * longint'(tr.x2);
    endfunction

    // Value an ow-bit result must hold: clamp, or two's-complement wrap.
    function automatic longint red_val(input longint s, input int ow, input bit sat);
        longint hi, lo, m;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -hi - 1;
        if (sat) begin
            if (s > hi) return hi;
            if (s < lo) return lo;
            return s;
        end
        m = s & ((longint'(1) << ow) - 1);
        if (m > hi) m = m - (longint'(1) << ow);
        return m;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alt(input int a, input int b);
        in_valid_d = 1'b1; sel_eq_d = EQ_ALT; x1_d = 8'(a); x2_d = 8'(b);
    endtask

    task automatic drive_bat(input int a, input int b, input int cc);
        in_valid_d = 1'b1; sel_eq_d = EQ_BAT; v_d = 8'(a); t_d = 8'(b); c_d = 8'(cc);
    endtask

    task automatic do_reset();
        in_valid_d = 1'b0; out_ready_d = 1'b1; rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic drain();
        in_valid_d = 1'b0; out_ready_d = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (q.size() == 0 && bus_a.out_valid == 1'b0) break;
            step();
        end
        chk("drain_empty", longint'(q.size()), 0);
        chk("drain_no_loss", longint'(m_acc), longint'(m_alt + m_bat));
    endtask

    task automatic check_a(input string name, input longint res, input bit eq);
        chk({name, "_valid"}, longint'(bus_a.out_valid), 1);
        chk({name, "_result"}, longint'(bus_a.out_result), res);
        chk({name, "_eq"}, longint'(bus_a.out_eq), longint'(eq));
    endtask

    // Reference scoreboard and per-cycle compare, sampled mid-cycle.
    initial begin
        txn_t   tr;
        longint ex;
        bit     stall_prev = 1'b0;
        longint prev_res = 0;
        longint prev_eq = 0;
        longint prev_sat = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                q.delete();
                m_alt = 0; m_bat = 0; m_acc = 0;
                stall_prev = 1'b0;
            end else begin
                chk("in_ready_rule", longint'(bus_a.in_ready), longint'(!bus_a.out_valid || out_ready_d));
                chk("valid_s", longint'(bus_s.out_valid), longint'(bus_a.out_valid));
                chk("valid_w", longint'(bus_w.out_valid), longint'(bus_a.out_valid));
                chk("alt_cnt_a", longint'(bus_a.alt_cnt), longint'(m_alt % 65536));
                chk("bat_cnt_a", longint'(bus_a.bat_cnt), longint'(m_bat % 65536));
                chk("alt_cnt_w", longint'(bus_w.alt_cnt), longint'(m_alt % 4));
                chk("bat_cnt_w", longint'(bus_w.bat_cnt), longint'(m_bat % 4));
                if (stall_prev) begin
                    chk("hold_result", longint'(bus_a.out_result), prev_res);
                    chk("hold_eq", longint'(bus_a.out_eq), prev_eq);
                    chk("hold_sat", longint'(bus_a.out_sat), prev_sat);
                end
                if (bus_a.out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_output", 1, 0);
                    end else begin
                        tr = q[0];
                        ex = exact(tr);
                        chk("res_a", longint'(bus_a.out_result), red_val(ex, 16, 1'b1));
                        chk("sat_a", longint'(bus_a.out_sat), longint'(red_val(ex, 16, 1'b1) != ex));
                        chk("eq_a", longint'(bus_a.out_eq), longint'(tr.sel));
                        chk("res_s", longint'(bus_s.out_result), red_val(ex, 10, 1'b1));
                        chk("sat_s", longint'(bus_s.out_sat), longint'(red_val(ex, 10, 1'b1) != ex));
                        chk("res_w", longint'(bus_w.out_result), red_val(ex, 10, 1'b0));
                        chk("sat_w", longint'(bus_w.out_sat), longint'(red_val(ex, 10, 1'b0) != ex));
                        if (out_ready_d) begin
                            void'(q.pop_front());
                            if (tr.sel) m_bat++;
                            else        m_alt++;
                        end
                    end
                end
                stall_prev = bus_a.out_valid && !out_ready_d;
                prev_res   = longint'(bus_a.out_result);
                prev_eq    = longint'(bus_a.out_eq);
                prev_sat   = longint'(bus_a.out_sat);
                if (in_valid_d && bus_a.in_ready) begin
                    tr.sel = sel_eq_d;
                    tr.x1 = int'(x1_d); tr.x2 = int'(x2_d);
                    tr.v = int'(v_d); tr.t = int'(t_d); tr.c = int'(c_d);
                    q.push_back(tr);
                    m_acc++;
                end
            end
        end
    end

    initial begin
        longint held;
        rst = 1'b0; in_valid_d = 1'b0; sel_eq_d = 1'b0; out_ready_d = 1'b1;
        x1_d = '0; x2_d = '0; v_d = '0; t_d = '0; c_d = '0;
        step(); step();
        rst = 1'b1;

        // Reset state
        chk("rst_out_valid", longint'(bus_a.out_valid), 0);
        chk("rst_in_ready", longint'(bus_a.in_ready), 1);
        chk("rst_alt_cnt", longint'(bus_a.alt_cnt), 0);
        chk("rst_bat_cnt", longint'(bus_a.bat_cnt), 0);
        chk("rst_out_result", longint'(bus_a.out_result), 0);

        // Hand-computed anchors for the reference arithmetic
        chk("model_wrap", red_val(16511, 10, 1'b0), 127);
        chk("model_clamp_hi", red_val(16511, 10, 1'b1), 511);
        chk("model_clamp_lo", red_val(-1024, 10, 1'b1), -512);

        // T1: two results exactly three cycles after being presented
        drive_alt(3, 4);
        step(); drive_bat(2, 5, 16);
        step(); in_valid_d = 1'b0;
        step(); check_a("t1_alt", 29, 1'b0);
        step(); check_a("t1_bat", 26, 1'b1);
        chk("t1_alt_cnt", longint'(bus_a.alt_cnt), 1);
        step();
        chk("t1_idle", longint'(bus_a.out_valid), 0);
        chk("t1_bat_cnt", longint'(bus_a.bat_cnt), 1);

        // T2: alternating equations every cycle
        do_reset();
        drive_alt(10, 15);       step();
        drive_bat(12, 8, 20);    step();
        drive_alt(-5, 7);        step();
        drive_bat(-3, -2, 10);   check_a("t2_r0", 105, 1'b0); step();
        in_valid_d = 1'b0;       check_a("t2_r1", 116, 1'b1); step();
        check_a("t2_r2", 20, 1'b0); step();
        check_a("t2_r3", 16, 1'b1); step();
        chk("t2_alt_cnt", longint'(bus_a.alt_cnt), 2);
        chk("t2_bat_cnt", longint'(bus_a.bat_cnt), 2);

        // T4: clamping and wrapping at OW=10
        do_reset();
        drive_bat(-128, -128, 127); step();
        drive_alt(-128, -128);      step();
        in_valid_d = 1'b0;          step();
        chk("t4_bat_s", longint'(bus_s.out_result), 511);
        chk("t4_bat_s_sat", longint'(bus_s.out_sat), 1);
        chk("t4_bat_w", longint'(bus_w.out_result), 127);
        chk("t4_bat_w_sat", longint'(bus_w.out_sat), 1);
        chk("t4_bat_a", longint'(bus_a.out_result), 16511);
        chk("t4_bat_a_sat", longint'(bus_a.out_sat), 0);
        step();
        chk("t4_alt_s", longint'(bus_s.out_result), -512);
        chk("t4_alt_s_sat", longint'(bus_s.out_sat), 1);
        chk("t4_alt_w_sat", longint'(bus_w.out_sat), 1);
        chk("t4_alt_a", longint'(bus_a.out_result), -1024);

        // T3: backpressure for five cycles while streaming
        do_reset();
        held = 0;
        for (int i = 0; i < 14; i++) begin
            out_ready_d = !(i >= 5 && i < 10);
            if (i % 2 == 0) drive_alt(int'($urandom_range(255, 0)) - 128, i);
            else            drive_bat(i, -i, int'($urandom_range(255, 0)) - 128);
            step();
            if (i == 5) held = longint'(bus_a.out_result);
            if (i > 5 && i < 10) begin
                chk("t3_in_ready_stall", longint'(bus_a.in_ready), 0);
                chk("t3_result_stable", longint'(bus_a.out_result), held);
            end
        end
        drain();
        chk("t3_cnt_total", longint'(bus_a.alt_cnt) + longint'(bus_a.bat_cnt), longint'(m_acc));

        // T5: reset with three transactions in flight
        do_reset();
        drive_alt(1, 2); step();
        drive_bat(3, 4, 5); step();
        drive_alt(6, 7); step();
        do_reset();
        chk("t5_out_valid", longint'(bus_a.out_valid), 0);
        chk("t5_alt_cnt", longint'(bus_a.alt_cnt), 0);
        chk("t5_bat_cnt", longint'(bus_a.bat_cnt), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", longint'(bus_a.out_valid), 0);
        end
        drive_alt(1, 1); step();
        in_valid_d = 1'b0; step(); step();
        check_a("t5_fresh", 8, 1'b0);
        step();

        // T6: 2-bit counter wrap after five ALT hand-offs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_alt(i, 1);
            step();
        end
        drain();
        chk("t6_alt_w", longint'(bus_w.alt_cnt), 1);
        chk("t6_bat_w", longint'(bus_w.bat_cnt), 0);
        chk("t6_alt_a", longint'(bus_a.alt_cnt), 5);

        // Random traffic with random backpressure
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid_d  = ($urandom_range(3, 0) != 0);
            sel_eq_d    = 1'($urandom_range(1, 0));
            x1_d = 8'($urandom_range(255, 0)); x2_d = 8'($urandom_range(255, 0));
            v_d  = 8'($urandom_range(255, 0)); t_d  = 8'($urandom_range(255, 0));
            c_d  = 8'($urandom_range(255, 0));
            out_ready_d = ($urandom_range(9, 0) < 7);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
